// File: rtl/dram_page_seq.sv
// DRAM page-mode access sequencer: page hit/miss control, tracker newrow/invalidate
// strobes and CAS-before-RAS refresh scheduling, with all outputs registered.
module dram_page_seq #(
   parameter int ROW_W   = 11,
   parameter int COL_W   = 10,
   parameter int T_RP    = 2,
   parameter int T_RCD   = 2,
   parameter int T_CAS   = 2,
   parameter int REF_INT = 390
) (
   input  logic             sys_clk,
   input  logic             resl,
   input  logic             req,
   input  logic             wr,
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   input  logic             match,
   output logic             ack,
   output logic             busy,
   output logic             newrow,
   output logic             rowinv_l,
   output logic [ROW_W-1:0] ma,
   output logic             ras_l,
   output logic             cas_l,
   output logic             we_l
);

   localparam int REF_W = $clog2(REF_INT);

   typedef enum logic [2:0] {IDLE, PRE, RAS, CAS, REF_PRE, REF_CAS, REF_RAS} state_t;

   state_t             state, state_n;
   logic [7:0]         cnt, cnt_n;
   logic               page_open, page_open_n;
   logic               ref_pend;
   logic [REF_W-1:0]   ref_cnt;
   logic               inv_n, ras_l_n, cas_l_n, we_l_n, ack_n, newrow_n, busy_n;
   logic [ROW_W-1:0]   ma_n;

   // NOTE: every variable is given a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch to hold the old value.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt + 8'd1;
      page_open_n = page_open;
      inv_n       = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (ref_pend) begin
               inv_n       = 1'b1;
               page_open_n = 1'b0;
               state_n     = page_open ? REF_PRE : REF_CAS;
            end else if (req) begin
               if (match && page_open) begin
                  state_n = CAS;
               end else if (page_open) begin
                  inv_n       = 1'b1;
                  page_open_n = 1'b0;
                  state_n     = PRE;
               end else begin
                  state_n = RAS;
               end
            end
         end
         PRE: if (cnt == 8'(T_RP - 1)) begin
            state_n = RAS;
            cnt_n   = '0;
         end
         RAS: begin
            page_open_n = 1'b1;
            if (cnt == 8'(T_RCD - 1)) begin
               state_n = CAS;
               cnt_n   = '0;
            end
         end
         CAS: if (cnt == 8'(T_CAS - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         REF_PRE: if (cnt == 8'(T_RP - 1)) begin
            state_n = REF_CAS;
            cnt_n   = '0;
         end
         REF_CAS: begin
            state_n = REF_RAS;
            cnt_n   = '0;
         end
         REF_RAS: if (cnt == 8'd1) begin
            state_n     = IDLE;
            cnt_n       = '0;
            page_open_n = 1'b0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      // Outputs are decoded from the upcoming state so the registers present
      // them in the same cycle the FSM occupies that state.
      case (state_n)
         IDLE:              ras_l_n = ~page_open_n;
         RAS, CAS, REF_RAS: ras_l_n = 1'b0;
         default:           ras_l_n = 1'b1;
      endcase
      cas_l_n  = !(state_n inside {CAS, REF_CAS, REF_RAS});
      we_l_n   = !((state_n == CAS) && wr);
      ack_n    = (state_n == CAS) && (cnt_n == 8'(T_CAS - 1));
      newrow_n = (state_n == RAS) && (state != RAS);
      busy_n   = (state_n != IDLE);
      ma_n     = ma;
      if (state_n == RAS)      ma_n = row;
      else if (state_n == CAS) ma_n = ROW_W'(col);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge sys_clk or negedge resl) begin
      if (!resl) begin
         state     <= IDLE;
         cnt       <= '0;
         page_open <= 1'b0;
         ras_l     <= 1'b1;
         cas_l     <= 1'b1;
         we_l      <= 1'b1;
         ack       <= 1'b0;
         newrow    <= 1'b0;
         busy      <= 1'b0;
         rowinv_l  <= 1'b0;
         ma        <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         page_open <= page_open_n;
         ras_l     <= ras_l_n;
         cas_l     <= cas_l_n;
         we_l      <= we_l_n;
         ack       <= ack_n;
         newrow    <= newrow_n;
         busy      <= busy_n;
         rowinv_l  <= ~inv_n;
         ma        <= ma_n;
      end
   end

   // Refresh timer: a pending refresh absorbs further expiries until serviced.
   always_ff @(posedge sys_clk or negedge resl) begin
      if (!resl) begin
         ref_cnt  <= REF_W'(REF_INT - 1);
         ref_pend <= 1'b0;
      end else if (ref_cnt == '0) begin
         ref_cnt  <= REF_W'(REF_INT - 1);
         ref_pend <= 1'b1;
      end else begin
         ref_cnt <= ref_cnt - REF_W'(1);
         if (state == REF_RAS) ref_pend <= 1'b0;
      end
   end

endmodule

// File: doc/dram_page_seq.md
# dram_page_seq

DRAM page-mode access sequencer for the ABUS memory controller. It accepts single-beat requests, uses the row-match signal from the per-bank open-row tracker to choose a page hit or a page miss, and drives RAS/CAS/WE and the multiplexed address. It is the control end of the tracker interface: it produces the `newrow` load pulse and the active-low row-invalidate strobe, which feed the tracker's `newrow`/`resl` inputs. It also schedules CAS-before-RAS refresh.

## Interface
- `ROW_W`, 11, row address width; also the `ma` width.
- `COL_W`, 10, column address width (≤ `ROW_W`); zero-extended onto `ma`.
- `T_RP`, 2, precharge cycles (≥1).
- `T_RCD`, 2, RAS-to-CAS cycles (≥1).
- `T_CAS`, 2, CAS-low cycles per access (≥1).
- `REF_INT`, 390, cycles between refresh requests (≥16).
- `sys_clk` in 1: clock; all state changes on its rising edge.
- `resl` in 1: reset, asynchronous, active-low.
- `req` in 1: request valid; held high until `ack`.
- `wr` in 1: 1 = write, 0 = read; stable while `req` is high.
- `row` in `ROW_W`: request row; stable while `req` is high.
- `col` in `COL_W`: request column; stable while `req` is high.
- `match` in 1: the tracker reports `row` equals the open row and the tracker is valid.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: FSM is not in IDLE.
- `newrow` out 1: one-cycle pulse that loads `row` into the tracker.
- `rowinv_l` out 1: active-low one-cycle pulse that invalidates the tracker.
- `ma` out `ROW_W`: multiplexed DRAM address.
- `ras_l`, `cas_l`, `we_l` out 1 each: DRAM strobes, active-low.

## Operation
- Reset values: `ras_l` = `cas_l` = `we_l` = 1; `ack` = `newrow` = `busy` = 0; `rowinv_l` = 0; `ma` = 0; `page_open` = 0; `ref_pend` = 0; `ref_cnt` = `REF_INT`-1; state = IDLE.
  - `rowinv_l` returns to 1 on the first clock after reset is released.
- Outputs are registered. Strobes are glitch-free.
- States: IDLE, PRE, RAS, CAS, REF_PRE, REF_CAS, REF_RAS.
- **IDLE**
  - `ras_l` = 0 if `page_open`, otherwise 1. `cas_l` = 1.
  - Priority: `ref_pend` first, then `req`.
  - Refresh: go to REF_PRE if `page_open`, otherwise REF_CAS. Pulse `rowinv_l` low on the transition.
  - Request, hit = `match` & `page_open`: go to CAS.
  - Request, miss with `page_open`: go to PRE and pulse `rowinv_l` low.
  - Request, miss with the page closed: go to RAS.
- **PRE**: `ras_l` = 1 for `T_RP` cycles, then go to RAS. `page_open` is cleared on entry.
- **RAS**
  - `ma` = `row`, `ras_l` = 0.
  - `newrow` = 1 in the first RAS cycle only. `page_open` is set.
  - After `T_RCD` cycles, go to CAS.
- **CAS**
  - `ma` = `col`, `cas_l` = 0, `we_l` = ~`wr`.
  - `ack` = 1 in the last of the `T_CAS` cycles. Then go to IDLE. `cas_l` and `we_l` return to 1.
- **REF_PRE**: `ras_l` = 1 for `T_RP` cycles, then go to REF_CAS. `page_open` is cleared.
- **REF_CAS**: `cas_l` = 0 for 1 cycle with `ras_l` = 1, then go to REF_RAS.
- **REF_RAS**
  - `ras_l` = 0 and `cas_l` = 0 for 2 cycles. `ref_pend` is cleared.
  - Then go to IDLE with both strobes at 1 and `page_open` = 0.
- **Refresh timer**
  - `ref_cnt` decrements every cycle.
  - At 0 it sets `ref_pend` and reloads to `REF_INT`-1.
  - Expiry while `ref_pend` is already set has no further effect (no accumulation).
- An access in progress is never preempted. A refresh request waits for IDLE.
- `match` is sampled only in IDLE with `req` high.

## Timing
- `req` is first sampled high in IDLE at edge N.
- Hit: CAS in cycles N+1..N+`T_CAS`; `ack` in cycle N+2 (defaults).
- Miss, page closed: RAS N+1..N+2, `newrow` in N+1, CAS N+3..N+4, `ack` in N+4.
- Miss, page open: `rowinv_l` low in N+1, PRE N+1..N+2, RAS N+3..N+4, `newrow` in N+3, CAS N+5..N+6, `ack` in N+6.
- After `ack`, the FSM is in IDLE on the next cycle. A `req` still high there starts a new access. Minimum hit-to-hit spacing is `T_CAS`+1 cycles.
- Refresh from IDLE with the page open takes `T_RP`+3 cycles (5 at defaults). With the page closed it takes 3 cycles.
- Reset asserted mid-access forces all reset values immediately; no `ack` is generated.

## Test plan
- Reset, then `req` with `wr`=0 and `row`=0x123 (`match`=0) -> page-closed miss: `newrow` 1 cycle after the accept edge; `ma`=0x123 during RAS; `ack` 4 cycles after accept; `we_l` stays 1.
- Same row again, tracker model asserting `match` -> hit: no `ras_l` rise; `ma`=`col`; `ack` 2 cycles after accept; `we_l`=0 during CAS when `wr`=1.
- Row 0x124 with the page open -> `rowinv_l` low 1 cycle; `ras_l` high 2 cycles; `newrow` with `ma`=0x124; `ack` 6 cycles after accept.
- `REF_INT`=16 and `req` held continuously -> refresh inserted only between accesses; `cas_l` falls 1 cycle before `ras_l`; the next access is a closed-page miss.
- Refresh expiry coincident with `req` in IDLE -> refresh first, then the request; exactly one refresh per expiry.
- `resl` asserted during PRE -> all strobes 1, `rowinv_l` 0, `busy` 0 asynchronously; after release the first access is a closed-page miss.
